// File: rtl/vram_host_arbiter_pkg.sv
// vram_host_arbiter_pkg: shared VRAM widths and host-side FSM state encodings.
package vram_host_arbiter_pkg;
    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;
    typedef logic [1:0] stateT;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;
endpackage

// File: rtl/vram_host_arbiter_if.sv
// vram_host_arbiter_if: host request port seen by the VRAM arbiter.
interface vram_host_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              hostSelect;
    logic              hostRd;
    logic [ADDR_W-1:0] hostAddr;
    logic [DATA_W-1:0] hostWrData;
    logic [DATA_W-1:0] hostRdData;
    logic              hostAck;
    modport master (output hostSelect, hostRd, hostAddr, hostWrData, input hostRdData, hostAck);
    modport slave (input hostSelect, hostRd, hostAddr, hostWrData, output hostRdData, hostAck);
endinterface

// File: rtl/vram_host_arbiter_starve_timer.sv
// vram_starve_timer: saturating count of cycles a host request has been kept waiting.
module vram_starve_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic nRst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(MAX_WAIT + 1);
    logic [W-1:0] waitCnt;
    assign expired = waitCnt == W'(MAX_WAIT);
    always_ff @(posedge clk or negedge nRst)
        if (!nRst) waitCnt <= '0;
        else if (clr) waitCnt <= '0;
        else if (inc && !expired) waitCnt <= waitCnt + 1'b1;
endmodule

// File: rtl/vram_host_arbiter.sv
// vram_host_arbiter: shares one synchronous VRAM port between display fetches (priority) and host accesses.
module vram_host_arbiter
    import vram_host_arbiter_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              nRst,
    vram_host_arbiter_if.slave host,
    input  logic              dispReq,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic              dispStall,
    output logic [DATA_W-1:0] dispData,
    output logic              dispValid,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWrData,
    output logic              ramWe,
    input  logic [DATA_W-1:0] ramRdData
);
    stateT             state, nextState;
    logic              selPrev, rdQ, expired, forceGrant, hostGrant, dispGrant, start, inPend;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wrDataQ;

    assign start      = host.hostSelect & ~selPrev;
    assign inPend     = state == ST_PEND;
    assign forceGrant = inPend & expired;
    assign hostGrant  = inPend & (~dispReq | forceGrant);
    assign dispGrant  = dispReq & ~forceGrant;
    assign dispStall  = dispReq & forceGrant;
    assign ramAddr    = hostGrant ? addrQ : dispAddr;
    assign ramWe      = hostGrant & ~rdQ;
    assign ramWrData  = wrDataQ;
    assign host.hostAck = state == ST_DONE;

    // HOLD keeps a still-asserted hostSelect from being seen as a fresh request
    assign nextState = (state == ST_IDLE) ? (start ? ST_PEND : ST_IDLE) :
                       (state == ST_PEND) ? (hostGrant ? ST_DONE : ST_PEND) :
                       (host.hostSelect ? ST_HOLD : ST_IDLE);

    vram_starve_timer #(.MAX_WAIT(MAX_WAIT)) starveTimer (
        .clk     (clk),
        .nRst    (nRst),
        .clr     (~inPend),
        .inc     (inPend & ~hostGrant),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge nRst)
        if (!nRst) begin
            state           <= ST_IDLE;
            selPrev         <= 1'b0;
            rdQ             <= 1'b0;
            addrQ           <= '0;
            wrDataQ         <= '0;
            host.hostRdData <= '0;
            dispData        <= '0;
            dispValid       <= 1'b0;
        end else begin
            state     <= nextState;
            selPrev   <= host.hostSelect;
            dispValid <= dispGrant;
            if (state == ST_IDLE && start) begin
                rdQ     <= host.hostRd;
                addrQ   <= host.hostAddr;
                wrDataQ <= host.hostWrData;
            end
            if (state == ST_DONE && rdQ) host.hostRdData <= ramRdData;
            if (dispValid) dispData <= ramRdData;
        end
endmodule

// File: tb/tb_vram_host_arbiter.sv
// tb_vram_host_arbiter: randomized and directed checks of the VRAM host arbiter against a transaction-level model.
module tb_vram_host_arbiter;
    localparam int MAXW = 15;

    logic        clk, nRst;
    logic        dispReq, dispStall, dispValid, ramWe;
    logic [12:0] dispAddr, ramAddr;
    logic [7:0]  dispData, ramWrData, ramRdData;

    vram_host_arbiter_if #(.ADDR_W(13), .DATA_W(8)) hostIf ();

    vram_host_arbiter #(.ADDR_W(13), .DATA_W(8), .MAX_WAIT(MAXW)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .host      (hostIf),
        .dispReq   (dispReq),
        .dispAddr  (dispAddr),
        .dispStall (dispStall),
        .dispData  (dispData),
        .dispValid (dispValid),
        .ramAddr   (ramAddr),
        .ramWrData (ramWrData),
        .ramWe     (ramWe),
        .ramRdData (ramRdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] initVal(input logic [12:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // VRAM: one-cycle synchronous read, read-before-write
    bit         ramWritten [0:8191];
    logic [7:0] ramMem     [0:8191];
    always @(posedge clk) begin
        ramRdData <= ramWritten[ramAddr] ? ramMem[ramAddr] : initVal(ramAddr);
        if (ramWe) begin
            ramMem[ramAddr]     <= ramWrData;
            ramWritten[ramAddr] <= 1'b1;
        end
    end

    function automatic logic [7:0] ramPeek(input logic [12:0] a);
        return ramWritten[a] ? ramMem[a] : initVal(a);
    endfunction

    logic [7:0] shadow [0:8191];
    logic [7:0] expRd, expDispData, d1, d2;
    bit         sv1, sv2;
    int         nChk, nPass;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nChk++;
        assert (got === exp) nPass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock cycle: inputs already driven, outputs checked mid-cycle, display pipeline modelled
    task automatic checkCycle(input bit grant, input bit rd, input logic [12:0] addr,
                              input logic [7:0] data, input bit ack, input bit stall);
        #1;
        if (sv2) expDispData = d2;
        chk("ramWe", ramWe, grant & ~rd);
        chk("ramAddr", ramAddr, grant ? addr : dispAddr);
        if (grant && !rd) chk("ramWrData", ramWrData, data);
        chk("hostAck", hostIf.hostAck, ack);
        chk("dispStall", dispStall, stall);
        chk("dispValid", dispValid, sv1);
        chk("dispData", dispData, expDispData);
        chk("hostRdData", hostIf.hostRdData, expRd);
        sv2 = sv1;
        d2  = d1;
        sv1 = dispReq & ~stall & nRst;
        d1  = shadow[dispAddr];
        if (grant && !rd) shadow[addr] = data;
        @(posedge clk);
        #1;
    endtask

    // A host access is granted after min(busy, MAXW) waiting cycles; display busy for `busy` cycles after the start
    task automatic hostAccess(input bit rd, input logic [12:0] addr, input logic [7:0] data,
                              input int busy, input int selLen);
        int g, n;
        g = busy < MAXW ? busy : MAXW;
        n = ((3 + g) > (selLen + 1) ? (3 + g) : (selLen + 1)) + 1;
        for (int k = 0; k < n; k++) begin
            hostIf.hostSelect = k < selLen;
            hostIf.hostRd     = k == 0 ? rd : 1'($urandom);
            hostIf.hostAddr   = k == 0 ? addr : 13'($urandom);
            hostIf.hostWrData = k == 0 ? data : 8'($urandom);
            dispReq  = k >= 1 && k <= busy;
            dispAddr = 13'($urandom_range(0, 63));
            if (rd && k == 3 + g) expRd = shadow[addr];
            checkCycle(k == 1 + g, rd, addr, data, k == 2 + g, busy > MAXW && k == 1 + MAXW);
        end
    endtask

    initial begin
        nChk = 0;
        nPass = 0;
        for (int i = 0; i < 8192; i++) shadow[i] = initVal(13'(i));
        sv1 = 0; sv2 = 0; d1 = '0; d2 = '0; expRd = '0; expDispData = '0;
        nRst = 1'b0;
        hostIf.hostSelect = 1'b0; hostIf.hostRd = 1'b0; hostIf.hostAddr = '0; hostIf.hostWrData = '0;
        dispReq = 1'b0; dispAddr = '0;
        @(posedge clk); #1;
        repeat (2) checkCycle(0, 0, '0, '0, 0, 0);
        nRst = 1'b1;
        checkCycle(0, 0, '0, '0, 0, 0);

        // Reset while a write is pending behind display traffic
        hostIf.hostSelect = 1'b1; hostIf.hostRd = 1'b0; hostIf.hostAddr = 13'h077; hostIf.hostWrData = 8'hEE;
        dispReq = 1'b1; dispAddr = 13'd5;
        checkCycle(0, 0, '0, '0, 0, 0);
        hostIf.hostSelect = 1'b0;
        repeat (4) checkCycle(0, 0, '0, '0, 0, 0);
        chk("t1 dispData before reset", dispData, 8'h5F);
        nRst = 1'b0;
        sv1 = 0; sv2 = 0; expDispData = '0; expRd = '0;
        repeat (2) checkCycle(0, 0, '0, '0, 0, 0);
        nRst = 1'b1;
        dispReq = 1'b0;
        checkCycle(0, 0, '0, '0, 0, 0);
        chk("t1 no write", ramPeek(13'h077), initVal(13'h077));

        // Idle display: minimum latency write then read-back
        hostAccess(0, 13'h1A5, 8'h3C, 0, 1);
        hostAccess(1, 13'h1A5, 8'h00, 0, 2);
        chk("t2 read data", hostIf.hostRdData, 8'h3C);

        // Display busy for 5 cycles, then host read
        hostAccess(1, 13'h0FF, 8'h00, 5, 2);
        chk("t3 read data", hostIf.hostRdData, initVal(13'h0FF));

        // Continuous display traffic: forced grant after MAXW
        hostAccess(0, 13'h020, 8'hA7, 30, 1);
        hostAccess(1, 13'h020, 8'h00, MAXW, 1);
        chk("t4 read data", hostIf.hostRdData, 8'hA7);

        // hostSelect held high through DONE and HOLD
        hostAccess(1, 13'h010, 8'h00, 0, 8);
        // hostSelect dropped while pending
        hostAccess(0, 13'h030, 8'h55, 3, 1);
        hostAccess(1, 13'h030, 8'h00, 0, 1);
        chk("t6 read data", hostIf.hostRdData, 8'h55);

        repeat (40)
            hostAccess(1'($urandom), 13'($urandom_range(0, 63)), 8'($urandom),
                       $urandom_range(0, 20), $urandom_range(1, 5));

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
